// File: rtl/pdh_pkg.sv
// Shared types and constants for the PDH capture path: capture FSM states,
// record width, word selects and record pack/unpack helpers.
package pdh_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int CAP_REC_W = 128;

  localparam logic [1:0] W_ERR_PERR  = 2'd0;
  localparam logic [1:0] W_DERR_IERR = 2'd1;
  localparam logic [1:0] W_SUMERR    = 2'd2;
  localparam logic [1:0] W_PIDOUT    = 2'd3;

  // Word n of a record sits at bits [32n+31:32n].
  function automatic logic [CAP_REC_W-1:0] rec_pack(
    input logic [15:0] err,
    input logic [15:0] perr,
    input logic [15:0] derr,
    input logic [15:0] ierr,
    input logic [31:0] sum_err,
    input logic [13:0] pid_out
  );
    return {18'b0, pid_out, sum_err, derr, ierr, err, perr};
  endfunction

  function automatic logic [31:0] rec_word(
    input logic [CAP_REC_W-1:0] rec,
    input logic [1:0]           sel
  );
    logic [31:0] w;
    w = rec[31:0];
    case (sel)
      W_ERR_PERR:  w = rec[31:0];
      W_DERR_IERR: w = rec[63:32];
      W_SUMERR:    w = rec[95:64];
      W_PIDOUT:    w = rec[127:96];
      default:     w = rec[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tap_capture_ram.sv
// Simple dual-port synchronous RAM for capture records. A read and a write to
// the same address in one cycle return the old contents (read-first).
module tap_capture_ram #(
  parameter int AW = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  // Write port and registered read port; NBA ordering gives read-first.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/pid_tap_capture.sv
// Decimated snapshot capture of the PID observation taps into an on-chip
// record buffer, with arm/trigger control and a 2-cycle pipelined readout.
module pid_tap_capture
  import pdh_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DEC_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic                    trig_mode_i,
  input  logic signed [15:0]      trig_level_i,
  input  logic [DEC_W-1:0]        decimate_i,
  input  logic signed [15:0]      err_tap_i,
  input  logic signed [15:0]      perr_tap_i,
  input  logic signed [15:0]      derr_tap_i,
  input  logic signed [15:0]      ierr_tap_i,
  input  logic signed [31:0]      sum_err_tap_i,
  input  logic [13:0]             pid_out_i,
  input  logic                    rd_req_i,
  input  logic [DEPTH_LOG2+1:0]   rd_addr_i,
  output logic                    rd_valid_o,
  output logic [31:0]             rd_data_o,
  output logic [1:0]              state_o,
  output logic [DEPTH_LOG2:0]     wr_count_o,
  output logic                    done_o
);

  localparam int                   DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEC_W-1:0]     DEC_ONE  = DEC_W'(1);
  localparam logic [DEPTH_LOG2:0]  CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]  CNT_LAST = (DEPTH_LOG2+1)'(DEPTH - 1);

  cap_state_t              state_q;
  logic                    mode_q;
  logic signed [15:0]      level_q;
  logic signed [15:0]      prev_q;
  logic                    prev_vld_q;
  logic [DEC_W-1:0]        div_q;
  logic [DEC_W-1:0]        cnt_q;
  logic [DEPTH_LOG2:0]     wr_count_q;
  logic                    done_q;

  logic                    we;
  logic                    trig_hit;
  logic [DEC_W-1:0]        div_d;
  logic [CAP_REC_W-1:0]    wdata;
  logic [CAP_REC_W-1:0]    ram_rdata;

  logic [1:0]              vld_pipe_q;
  logic [1:0]              rd_sel_q;
  logic [31:0]             rd_data_q;

  // A divisor of 0 behaves like 1 (sample every cycle).
  assign div_d = (decimate_i == '0) ? DEC_ONE : decimate_i;

  // Upward crossing of the level; needs one registered sample first.
  assign trig_hit = prev_vld_q && (prev_q < level_q) && (err_tap_i >= level_q);

  // Abort and reset suppress the write so an aborted capture leaves the
  // buffer and count exactly as they were.
  assign we = (state_q == CAPTURE) && (cnt_q == '0) && !abort_i && !rst;

  assign wdata = rec_pack(err_tap_i, perr_tap_i, derr_tap_i, ierr_tap_i,
                          sum_err_tap_i, pid_out_i);

  // Capture control FSM: arming, trigger detect, decimation and record count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      level_q    <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      div_q      <= DEC_ONE;
      cnt_q      <= '0;
      wr_count_q <= '0;
      done_q     <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm_i) begin
            mode_q     <= trig_mode_i;
            level_q    <= trig_level_i;
            div_q      <= div_d;
            wr_count_q <= '0;
            prev_vld_q <= 1'b0;
            done_q     <= 1'b0;
            state_q    <= ARMED;
          end
        end
        ARMED: begin
          prev_q     <= err_tap_i;
          prev_vld_q <= 1'b1;
          cnt_q      <= '0;
          if (!mode_q || trig_hit) state_q <= CAPTURE;
        end
        CAPTURE: begin
          cnt_q <= (cnt_q == div_q - DEC_ONE) ? '0 : cnt_q + DEC_ONE;
          if (we) begin
            wr_count_q <= wr_count_q + CNT_ONE;
            if (wr_count_q == CNT_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  tap_capture_ram #(
    .AW (DEPTH_LOG2),
    .DW (CAP_REC_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_count_q[DEPTH_LOG2-1:0]),
    .wdata_i (wdata),
    .re_i    (rd_req_i),
    .raddr_i (rd_addr_i[DEPTH_LOG2+1:2]),
    .rdata_o (ram_rdata)
  );

  // Read valid shift register and word select aligned with the RAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      rd_sel_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], rd_req_i};
      if (rd_req_i) rd_sel_q <= rd_addr_i[1:0];
    end
  end

  // Output word register; holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (vld_pipe_q[0]) begin
      rd_data_q <= rec_word(ram_rdata, rd_sel_q);
    end
  end

  assign rd_valid_o = vld_pipe_q[1];
  assign rd_data_o  = rd_data_q;
  assign state_o    = state_q;
  assign wr_count_o = wr_count_q;
  assign done_o     = done_q;

endmodule
